// File: rtl/bullet_damage_calc_pkg.sv
// bullet_damage_calc_pkg: definitions shared by the collision/damage side of the bullet store.
//   - bullet colour codes
//   - bit ranges of the packed position and size words
//   - bullet count, index width and the damage FSM state type
package bullet_damage_calc_pkg;

    localparam logic [2:0] WHITE = 3'b000;
    localparam logic [2:0] GREEN = 3'b001;
    localparam logic [2:0] BLUE  = 3'b010;

    // bullet_position = {x, y}, bullet_size = {w, h}
    localparam int unsigned POS_X_MSB  = 15;
    localparam int unsigned POS_X_LSB  = 8;
    localparam int unsigned POS_Y_MSB  = 7;
    localparam int unsigned POS_Y_LSB  = 0;
    localparam int unsigned SIZE_W_MSB = 15;
    localparam int unsigned SIZE_W_LSB = 8;
    localparam int unsigned SIZE_H_MSB = 7;
    localparam int unsigned SIZE_H_LSB = 0;

    localparam int unsigned NUM_BULLETS = 8;
    localparam int unsigned IDX_W       = 3;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StApply,
        StDead
    } dmg_state_e;

endpackage

// File: rtl/bullet_damage_calc_aabb_overlap.sv
// aabb_overlap: combinational strict axis-aligned box overlap test on 8-bit boxes.
//   ax, ay, aw, ah : box A left, top, width, height
//   bx, by, bw, bh : box B left, top, width, height
//   overlap        : 1 when the boxes share at least one pixel
// Edges are computed at 9 bits so boxes near 255 never wrap; an empty box never overlaps.
module aabb_overlap (
    input  logic [7:0] ax,
    input  logic [7:0] ay,
    input  logic [7:0] aw,
    input  logic [7:0] ah,
    input  logic [7:0] bx,
    input  logic [7:0] by,
    input  logic [7:0] bw,
    input  logic [7:0] bh,
    output logic       overlap
);

    logic [8:0] a_right, a_bottom, b_right, b_bottom;
    logic       non_empty;

    always_comb begin
        a_right   = {1'b0, ax} + {1'b0, aw};
        a_bottom  = {1'b0, ay} + {1'b0, ah};
        b_right   = {1'b0, bx} + {1'b0, bw};
        b_bottom  = {1'b0, by} + {1'b0, bh};
        non_empty = (aw != 8'd0) && (ah != 8'd0) && (bw != 8'd0) && (bh != 8'd0);
        overlap   = non_empty
                    && ({1'b0, ax} < b_right)  && ({1'b0, bx} < a_right)
                    && ({1'b0, ay} < b_bottom) && ({1'b0, by} < a_bottom);
    end

endmodule

// File: rtl/bullet_damage_calc.sv
// bullet_damage_calc: per-frame collision scan of the bullet store against the player heart,
// applying damage/heal with invincibility frames and a sticky dead flag.
//   clk, reset        : clock, synchronous active-high reset
//   tick              : frame pulse, starts a scan when idle
//   player_x/_y       : heart box top-left; player_moving arms blue bullets
//   bullet_index      : index driven to the store's collision read port (combinational data)
//   bullet_position/_size/_color/_is_render : store data for bullet_index
//   hp, hit, invincible, dead, busy : status outputs
// Optional: define BULLET_HIT_COUNT_EN to add hit_count[15:0], a saturating count of hit pulses.
module bullet_damage_calc
    import bullet_damage_calc_pkg::*;
#(
    parameter int unsigned MAX_HP   = 20,
    parameter int unsigned DAMAGE   = 3,
    parameter int unsigned HEAL     = 1,
    parameter int unsigned IFRAMES  = 30,
    parameter int unsigned PLAYER_W = 8,
    parameter int unsigned PLAYER_H = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [7:0]       player_x,
    input  logic [7:0]       player_y,
    input  logic             player_moving,
    output logic [IDX_W-1:0] bullet_index,
    input  logic [15:0]      bullet_position,
    input  logic [15:0]      bullet_size,
    input  logic [2:0]       bullet_color,
    input  logic             bullet_is_render,
    output logic [7:0]       hp,
    output logic             hit,
    output logic             invincible,
    output logic             dead,
    output logic             busy
`ifdef BULLET_HIT_COUNT_EN
    ,
    output logic [15:0]      hit_count
`endif
);

    localparam logic [7:0] MaxHp8   = 8'(MAX_HP);
    localparam logic [7:0] Damage8  = 8'(DAMAGE);
    localparam logic [8:0] Heal9    = 9'(HEAL);
    localparam logic [7:0] Iframes8 = 8'(IFRAMES);

    dmg_state_e state;
    logic [7:0] ifr_cnt;
    logic       dmg_flag, heal_flag;

    logic       overlap, counted, bullet_dmg, bullet_heal;
    logic       dmg_apply;
    logic [7:0] hp_dmg, hp_heal, hp_next;
    logic [8:0] heal_sum;

    aabb_overlap u_aabb_overlap (
        .ax      (player_x),
        .ay      (player_y),
        .aw      (8'(PLAYER_W)),
        .ah      (8'(PLAYER_H)),
        .bx      (bullet_position[POS_X_MSB:POS_X_LSB]),
        .by      (bullet_position[POS_Y_MSB:POS_Y_LSB]),
        .bw      (bullet_size[SIZE_W_MSB:SIZE_W_LSB]),
        .bh      (bullet_size[SIZE_H_MSB:SIZE_H_LSB]),
        .overlap (overlap)
    );

    always_comb begin
        counted     = bullet_is_render && overlap;
        bullet_dmg  = counted && ((bullet_color == WHITE)
                                  || ((bullet_color == BLUE) && player_moving));
        bullet_heal = counted && (bullet_color == GREEN);

        // Damage only lands outside invincibility; a landed hit suppresses the heal.
        dmg_apply = dmg_flag && (ifr_cnt == 8'd0);
        hp_dmg    = (hp > Damage8) ? (hp - Damage8) : 8'd0;
        heal_sum  = {1'b0, hp} + Heal9;
        hp_heal   = (heal_sum > {1'b0, MaxHp8}) ? MaxHp8 : heal_sum[7:0];
        if (dmg_apply) begin
            hp_next = hp_dmg;
        end else if (heal_flag) begin
            hp_next = hp_heal;
        end else begin
            hp_next = hp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            bullet_index <= '0;
            dmg_flag     <= 1'b0;
            heal_flag    <= 1'b0;
            ifr_cnt      <= 8'd0;
            hp           <= MaxHp8;
            hit          <= 1'b0;
            dead         <= 1'b0;
        end else begin
            hit <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tick) begin
                        dmg_flag     <= 1'b0;
                        heal_flag    <= 1'b0;
                        bullet_index <= '0;
                        state        <= StScan;
                    end
                end
                StScan: begin
                    dmg_flag  <= dmg_flag | bullet_dmg;
                    heal_flag <= heal_flag | bullet_heal;
                    // Index wraps to 0 naturally after the last bullet.
                    bullet_index <= bullet_index + 1'b1;
                    if (bullet_index == IDX_W'(NUM_BULLETS - 1)) begin
                        state <= StApply;
                    end
                end
                StApply: begin
                    if (dmg_apply) begin
                        ifr_cnt <= Iframes8;
                        hit     <= 1'b1;
                    end else if (ifr_cnt != 8'd0) begin
                        ifr_cnt <= ifr_cnt - 8'd1;
                    end
                    hp <= hp_next;
                    if (hp_next == 8'd0) begin
                        dead  <= 1'b1;
                        state <= StDead;
                    end else begin
                        state <= StIdle;
                    end
                end
                StDead: begin
                    hp <= 8'd0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy       = (state == StScan) || (state == StApply);
    assign invincible = (ifr_cnt != 8'd0);

`ifdef BULLET_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= 16'd0;
        end else if (hit && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule
